cmp_burst: RTL
==============

CMP_BURST -- requirements
Module: cmp_burst

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand width in bits (minimum 1).
REQ-002 SHALL have parameter LEN_W, default 8, the width of the burst length and counters (minimum 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a burst; sampled only in IDLE.
REQ-006 SHALL have port len  input  LEN_W  number of operand pairs in the burst; latched on an accepted start.
REQ-007 SHALL have port mode  input  2  compare mode, latched on an accepted start: 00 a==b, 01 a!=b, 10 a<b unsigned, 11 a>b unsigned.
REQ-008 SHALL have port in_valid  input  1  operand pair a/b is valid.
REQ-009 SHALL have port in_ready  output  1  block accepts the pair this cycle.
REQ-010 SHALL have port a  input  WIDTH  first operand.
REQ-011 SHALL have port b  input  WIDTH  second operand.
REQ-012 SHALL have port res_valid  output  1  res holds a valid per-pair result.
REQ-013 SHALL have port res_ready  input  1  downstream consumes res this cycle.
REQ-014 SHALL have port res  output  1  per-pair compare result.
REQ-015 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-016 SHALL have port done  output  1  one-cycle pulse at the end of a burst.
REQ-017 SHALL have port match_cnt  output  LEN_W  count of true results in the current or last burst.
REQ-018 SHALL have port all_match  output  1  every result in the burst was true.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-020 SHALL ignore start outside IDLE; an accepted start latches len and mode and clears match_cnt.
REQ-021 SHALL, on an accepted start, set all_match=1, and go IDLE->RUN if len!=0, else IDLE->DONE.
REQ-022 SHALL drive in_ready = (state==RUN) && (!res_valid || res_ready); in_ready SHALL be 0 in IDLE, DRAIN and DONE.
REQ-023 SHALL accept a pair on in_valid && in_ready; res and res_valid SHALL be registered with a latency of 1 cycle from the accept edge.
REQ-024 SHALL hold res stable while res_valid && !res_ready, and SHALL clear res_valid on res_ready with no new accept in the same cycle.
REQ-025 SHALL, on each accept whose result is true, increment match_cnt by 1, and on each accept whose result is false, clear all_match; match_cnt cannot exceed len, so there is no wrap.
REQ-026 SHALL count remaining pairs down from len and, on the accept of the last pair, go RUN->DRAIN.
REQ-027 SHALL leave DRAIN when res_valid is 0 or when res_valid && res_ready, and go to DONE.
REQ-028 SHALL assert done for exactly one cycle in DONE, then go DONE->IDLE.
REQ-029 SHALL hold match_cnt and all_match from DONE until the next accepted start.
REQ-030 SHALL accept a start in the first IDLE cycle after DONE (back-to-back bursts).
REQ-031 SHALL ignore mode changes during a burst; the latched mode applies.

Reset
REQ-032 SHALL, on rst_n low at any time including mid-burst, immediately force state=IDLE, res_valid=0, res=0, in_ready=0, busy=0, done=0, match_cnt=0, all_match=0 (and first_miss_vld=0, first_miss_idx=0 when CMP_MISS_IDX_EN is defined); a pending result is discarded.

Configuration
REQ-033 SHALL, with macro CMP_MISS_IDX_EN defined, add outputs first_miss_vld (1 bit) and first_miss_idx (LEN_W bits), the zero-based index of the first false result; both cleared on start, held until the next start.
REQ-034 SHALL, without CMP_MISS_IDX_EN, not have these ports and keep all other behaviour identical.

Verification
REQ-035 SHALL cover: reset release -> every output 0, in_ready 0.
REQ-036 SHALL cover: WIDTH=8, start len=4 mode=00, pairs (00,01)(01,01)(02,03)(03,03), res_ready=1 -> res 0,1,0,1 one cycle after each accept; match_cnt=2; all_match=0; done pulses once; first_miss_idx=0 with the macro defined.
REQ-037 SHALL cover: res_ready low for 3 cycles mid-burst -> in_ready=0, res held stable; no pair lost or duplicated, final match_cnt correct.
REQ-038 SHALL cover: start with len=0 -> done high the next cycle, match_cnt=0, all_match=1, busy never high.
REQ-039 SHALL cover: mode=11 with a=FF, b=00 -> res=1; mode=10 with a=00, b=80 -> res=1; mode=01 with a=b=5A -> res=0.
REQ-040 SHALL cover: rst_n low after 2 of 4 pairs -> all outputs 0 immediately; a new start after release runs a clean burst.

Source files
------------

// File: rtl/cmp_burst.sv
// Burst comparator: compares len operand pairs under a latched mode and tallies true results.
// Optional CMP_MISS_IDX_EN adds first_miss_vld/first_miss_idx reporting the first false pair.
module cmp_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] match_cnt,
`ifdef CMP_MISS_IDX_EN
  output logic             first_miss_vld,
  output logic [LEN_W-1:0] first_miss_idx,
`endif
  output logic             all_match
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] match_q, match_d;
  logic [1:0]       mode_q, mode_d;
  logic             res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             all_q, all_d;
  logic             cmp_c;
  logic             accept_c;
`ifdef CMP_MISS_IDX_EN
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] miss_idx_q, miss_idx_d;
  logic             miss_vld_q, miss_vld_d;
`endif

  // A new pair may enter only when the result slot is free or being drained this cycle.
  assign in_ready = (state_q == S_RUN) && (!res_valid_q || res_ready);
  assign accept_c = in_valid && in_ready;

  always_comb begin
    cmp_c = 1'b0;
    case (mode_q)
      2'b00:   cmp_c = (a == b);
      2'b01:   cmp_c = (a != b);
      2'b10:   cmp_c = (a < b);
      default: cmp_c = (a > b);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    match_d     = match_q;
    mode_d      = mode_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    all_d       = all_q;
`ifdef CMP_MISS_IDX_EN
    idx_d      = idx_q;
    miss_idx_d = miss_idx_q;
    miss_vld_d = miss_vld_q;
`endif
    if (res_valid_q && res_ready) res_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = len;
          mode_d  = mode;
          match_d = '0;
          all_d   = 1'b1;
`ifdef CMP_MISS_IDX_EN
          idx_d      = '0;
          miss_idx_d = '0;
          miss_vld_d = 1'b0;
`endif
          state_d = (len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (accept_c) begin
          res_d       = cmp_c;
          res_valid_d = 1'b1;
          rem_d       = rem_q - LEN_W'(1);
          if (cmp_c) match_d = match_q + LEN_W'(1);
          else       all_d   = 1'b0;
`ifdef CMP_MISS_IDX_EN
          idx_d = idx_q + LEN_W'(1);
          if (!cmp_c && !miss_vld_q) begin
            miss_vld_d = 1'b1;
            miss_idx_d = idx_q;
          end
`endif
          if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!res_valid_q || res_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      match_q     <= '0;
      mode_q      <= 2'b00;
      res_q       <= 1'b0;
      res_valid_q <= 1'b0;
      all_q       <= 1'b0;
`ifdef CMP_MISS_IDX_EN
      idx_q      <= '0;
      miss_idx_q <= '0;
      miss_vld_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      match_q     <= match_d;
      mode_q      <= mode_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      all_q       <= all_d;
`ifdef CMP_MISS_IDX_EN
      idx_q      <= idx_d;
      miss_idx_q <= miss_idx_d;
      miss_vld_q <= miss_vld_d;
`endif
    end
  end

  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign match_cnt = match_q;
  assign all_match = all_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
`ifdef CMP_MISS_IDX_EN
  assign first_miss_vld = miss_vld_q;
  assign first_miss_idx = miss_idx_q;
`endif

endmodule
